// File: rtl/serial_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops, bit-serial shifts.
// Valid/ready on both sides; result and branch flag are registered and held until taken.
module serial_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_op,
  input  logic [31:0] alu_in_1,
  input  logic [31:0] alu_in_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_result,
  output logic        alu_bcond
);

  localparam logic [3:0] FuncAdd = 4'd0;
  localparam logic [3:0] FuncSub = 4'd1;
  localparam logic [3:0] FuncAnd = 4'd2;
  localparam logic [3:0] FuncOr  = 4'd3;
  localparam logic [3:0] FuncXor = 4'd4;
  localparam logic [3:0] FuncLls = 4'd5;
  localparam logic [3:0] FuncLrs = 4'd6;
  localparam logic [3:0] FuncArs = 4'd7;
  localparam logic [3:0] FuncBeq = 4'd8;
  localparam logic [3:0] FuncBne = 4'd9;
  localparam logic [3:0] FuncBlt = 4'd10;
  localparam logic [3:0] FuncBge = 4'd11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] work_q, work_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        bcond_q, bcond_d;

  logic        in_is_shift;
  logic [4:0]  in_shamt;
  logic [31:0] comb_result;
  logic        comb_bcond;
  logic [31:0] work_shifted;

  assign in_shamt    = alu_in_2[4:0];
  assign in_is_shift = (alu_op == FuncLls) || (alu_op == FuncLrs) || (alu_op == FuncArs);

  // Single-cycle datapath for every non-shift op; unknown encodings fall back to add.
  always_comb begin
    comb_result = 32'd0;
    comb_bcond  = 1'b0;
    case (alu_op)
      FuncSub: comb_result = alu_in_1 - alu_in_2;
      FuncAnd: comb_result = alu_in_1 & alu_in_2;
      FuncOr:  comb_result = alu_in_1 | alu_in_2;
      FuncXor: comb_result = alu_in_1 ^ alu_in_2;
      FuncBeq: comb_bcond  = (alu_in_1 == alu_in_2);
      FuncBne: comb_bcond  = (alu_in_1 != alu_in_2);
      FuncBlt: comb_bcond  = ($signed(alu_in_1) < $signed(alu_in_2));
      FuncBge: comb_bcond  = ($signed(alu_in_1) >= $signed(alu_in_2));
      default: comb_result = alu_in_1 + alu_in_2;
    endcase
  end

  // One-bit step of the captured shift op.
  always_comb begin
    work_shifted = work_q;
    case (op_q)
      FuncLls: work_shifted = {work_q[30:0], 1'b0};
      FuncLrs: work_shifted = {1'b0, work_q[31:1]};
      FuncArs: work_shifted = {work_q[31], work_q[31:1]};
      default: work_shifted = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    op_d     = op_q;
    result_d = result_q;
    bcond_d  = bcond_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_is_shift && (in_shamt != 5'd0)) begin
            state_d = StShift;
            cnt_d   = in_shamt;
            work_d  = alu_in_1;
            op_d    = alu_op;
          end else if (in_is_shift) begin
            state_d  = StDone;
            result_d = alu_in_1;
            bcond_d  = 1'b0;
          end else begin
            state_d  = StDone;
            result_d = comb_result;
            bcond_d  = comb_bcond;
          end
        end
      end
      StShift: begin
        work_d = work_shifted;
        cnt_d  = cnt_q - 5'd1;
        // Final bit shift publishes the result on the same edge.
        if (cnt_q == 5'd1) begin
          state_d  = StDone;
          result_d = work_shifted;
          bcond_d  = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      work_q   <= 32'd0;
      op_q     <= FuncAdd;
      result_q <= 32'd0;
      bcond_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op_q     <= op_d;
      result_q <= result_d;
      bcond_q  <= bcond_d;
    end
  end

  assign in_ready   = (state_q == StIdle) && !reset;
  assign out_valid  = (state_q == StDone);
  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu: arithmetic, compares, serial shifts,
// back-pressure and mid-operation reset.
module tb_serial_alu;

  localparam logic [3:0] FuncAdd = 4'd0;
  localparam logic [3:0] FuncSub = 4'd1;
  localparam logic [3:0] FuncAnd = 4'd2;
  localparam logic [3:0] FuncOr  = 4'd3;
  localparam logic [3:0] FuncXor = 4'd4;
  localparam logic [3:0] FuncLls = 4'd5;
  localparam logic [3:0] FuncLrs = 4'd6;
  localparam logic [3:0] FuncArs = 4'd7;
  localparam logic [3:0] FuncBeq = 4'd8;
  localparam logic [3:0] FuncBne = 4'd9;
  localparam logic [3:0] FuncBlt = 4'd10;
  localparam logic [3:0] FuncBge = 4'd11;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        alu_bcond;

  int checks = 0;
  int errors = 0;

  serial_alu dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    alu_in_1 = a;
    alu_in_2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [31:0] res, input logic bc);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, alu_result, res);
    check({tag, "_bcond"}, {31'd0, alu_bcond}, {31'd0, bc});
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_op    = FuncAdd;
    alu_in_1  = 32'd0;
    alu_in_2  = 32'd0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_bcond", {31'd0, alu_bcond}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD wraps; one-cycle latency, then back to IDLE with result held.
    issue(FuncAdd, 32'hFFFF_FFFF, 32'h0000_0002);
    expect_done("add", 32'h0000_0001, 1'b0);
    tick();
    check("add_idle_valid", {31'd0, out_valid}, 32'd0);
    check("add_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("add_idle_hold", alu_result, 32'h0000_0001);

    issue(FuncBlt, 32'hFFFF_FFFE, 32'h0000_0001);
    expect_done("blt", 32'd0, 1'b1);
    tick();
    issue(FuncBge, 32'hFFFF_FFFE, 32'h0000_0001);
    expect_done("bge", 32'd0, 1'b0);
    tick();
    issue(FuncBeq, 32'h1234_5678, 32'h1234_5678);
    expect_done("beq", 32'd0, 1'b1);
    tick();
    issue(FuncBne, 32'h1234_5678, 32'h1234_5678);
    expect_done("bne", 32'd0, 1'b0);
    tick();
    issue(FuncAnd, 32'hF0F0_F0F0, 32'hFFFF_0000);
    expect_done("and", 32'hF0F0_0000, 1'b0);
    tick();
    issue(FuncOr, 32'hF0F0_F0F0, 32'hFFFF_0000);
    expect_done("or", 32'hFFFF_F0F0, 1'b0);
    tick();
    issue(4'hF, 32'h0000_0001, 32'h0000_0002);
    expect_done("undef_op", 32'h0000_0003, 1'b0);
    tick();

    // ARS by 31: busy for 31 cycles, previous result stays visible meanwhile.
    issue(FuncArs, 32'h8000_0000, 32'h0000_001F);
    for (int i = 0; i <= 30; i++) begin
      check($sformatf("ars_busy_valid_%0d", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("ars_busy_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("ars_busy_hold_%0d", i), alu_result, 32'h0000_0003);
      if (i < 30) tick();
    end
    tick();
    expect_done("ars", 32'hFFFF_FFFF, 1'b0);
    tick();
    issue(FuncLrs, 32'h8000_0000, 32'h0000_001F);
    for (int i = 0; i < 30; i++) tick();
    check("lrs_before_done", {31'd0, out_valid}, 32'd0);
    tick();
    expect_done("lrs", 32'h0000_0001, 1'b0);
    tick();

    // Shift by 0 via upper shamt bits ignored.
    issue(FuncLls, 32'h0000_0003, 32'hFFFF_FFE0);
    expect_done("lls0", 32'h0000_0003, 1'b0);
    tick();

    // Back-pressure: result held, in_valid ignored while DONE.
    out_ready = 1'b0;
    issue(FuncSub, 32'd5, 32'd7);
    expect_done("sub", 32'hFFFF_FFFE, 1'b0);
    in_valid = 1'b1;
    alu_op   = FuncAdd;
    alu_in_1 = 32'd1;
    alu_in_2 = 32'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_done($sformatf("sub_hold%0d", i), 32'hFFFF_FFFE, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("sub_idle_valid", {31'd0, out_valid}, 32'd0);
    check("sub_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("sub_idle_hold", alu_result, 32'hFFFF_FFFE);

    // Reset in the middle of a 20-bit shift.
    issue(FuncLls, 32'h0000_0001, 32'd20);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", alu_result, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
        if (out_valid) seen_valid = 1'b1;
        tick();
      end
      check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
    end
    issue(FuncXor, 32'hF0F0_F0F0, 32'hFFFF_0000);
    expect_done("xor", 32'h0F0F_F0F0, 1'b0);
    tick();
    check("xor_idle_in_ready", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
